dsp_mac_sequencer: RTL and testbench

- Sequences one DSP48A1 slice as a multiply-accumulate engine. Each job computes the dot product sum(a_i*b_i) over LEN operand pairs.
- Accepts a job command, then streams 18-bit operand pairs in through a valid/ready handshake.
- Drives the slice's A/B ports and OPMODE, with OPMODE time-aligned to the slice's internal pipeline.
- Returns the 48-bit P result through a one-cycle result strobe.
- Sits between upstream operand producers and a DSP48A1 instance configured with A0REG=0, A1REG=1, B0REG=0, B1REG=1, MREG=1, PREG=1, OPMODEREG=1, B_INPUT="DIRECT", CARRYINSEL="OPMODE5".

---
 rtl/dsp_mac_sequencer.sv | 131 +++++++++++++
 tb/tb_dsp_mac_sequencer.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dsp_mac_sequencer.sv
// Drives a DSP48A1 slice as a multiply-accumulate engine: accepts a job of LEN operand
// pairs, issues them to the slice with pipeline-aligned OPMODE and returns the dot product.
module dsp_mac_sequencer #(
  parameter int unsigned LEN_W    = 8,
  parameter int unsigned PIPE_LAT = 3,
  parameter int unsigned OPM_DLY  = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [LEN_W-1:0]   len,
  output logic               busy,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [17:0]        in_a,
  input  logic [17:0]        in_b,
  output logic               res_valid,
  output logic [47:0]        res_data,
  output logic [17:0]        dsp_a,
  output logic [17:0]        dsp_b,
  output logic [7:0]         dsp_opmode,
  input  logic [47:0]        dsp_p
);

  localparam logic [7:0] OpmFirst = 8'h01;
  localparam logic [7:0] OpmAcc   = 8'h09;
  localparam logic [7:0] OpmHold  = 8'h08;

  typedef enum logic [1:0] {StIdle, StLoad, StDrain, StDone} state_e;

  typedef struct packed {
    logic valid;
    logic first;
    logic last;
  } tag_t;

  state_e               state_q, state_d;
  logic [LEN_W-1:0]     remaining_q, remaining_d;
  logic                 first_q, first_d;
  logic [47:0]          res_data_q, res_data_d;
  logic [17:0]          dsp_a_q, dsp_b_q;
  tag_t [PIPE_LAT:0]    tag_q;
  tag_t                 new_tag;
  tag_t                 opm_tag;
  tag_t                 out_tag;
  logic                 accept;

  assign in_ready = (state_q == StLoad) && (remaining_q != '0);
  assign accept   = in_ready && in_valid;
  assign opm_tag  = tag_q[OPM_DLY];
  assign out_tag  = tag_q[PIPE_LAT];

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    first_d     = first_q;
    res_data_d  = res_data_q;
    new_tag     = '0;
    if (accept) begin
      new_tag.valid = 1'b1;
      new_tag.first = first_q;
      new_tag.last  = (remaining_q == LEN_W'(1));
    end
    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (len != '0) begin
            remaining_d = len;
            first_d     = 1'b1;
            state_d     = StLoad;
          end else begin
            res_data_d = '0;
            state_d    = StDone;
          end
        end
      end
      StLoad: begin
        if (accept) begin
          remaining_d = remaining_q - LEN_W'(1);
          first_d     = 1'b0;
          if (remaining_q == LEN_W'(1)) state_d = StDrain;
        end
      end
      StDrain: begin
        // P holds the whole sum once the last slot has travelled the full slice pipeline.
        if (out_tag.valid && out_tag.last) begin
          res_data_d = dsp_p;
          state_d    = StDone;
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    dsp_opmode = OpmHold;
    if ((state_q == StLoad || state_q == StDrain) && opm_tag.valid) begin
      dsp_opmode = opm_tag.first ? OpmFirst : OpmAcc;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      remaining_q <= '0;
      first_q     <= 1'b0;
      res_data_q  <= '0;
      dsp_a_q     <= '0;
      dsp_b_q     <= '0;
      tag_q       <= '0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      first_q     <= first_d;
      res_data_q  <= res_data_d;
      tag_q       <= {tag_q[PIPE_LAT-1:0], new_tag};
      if (accept) begin
        dsp_a_q <= in_a;
        dsp_b_q <= in_b;
      end
    end
  end

  assign busy      = (state_q != StIdle);
  assign res_valid = (state_q == StDone);
  assign res_data  = res_data_q;
  assign dsp_a     = dsp_a_q;
  assign dsp_b     = dsp_b_q;

endmodule

// File: tb/tb_dsp_mac_sequencer.sv
// Directed bench for dsp_mac_sequencer with a behavioural DSP48A1 slice model
// (A1REG/B1REG, MREG, OPMODEREG, PREG) closing the loop on dsp_p.
module tb_dsp_mac_sequencer;
  localparam int LEN_W = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [LEN_W-1:0]  len;
  logic              busy;
  logic              in_valid;
  logic              in_ready;
  logic [17:0]       in_a;
  logic [17:0]       in_b;
  logic              res_valid;
  logic [47:0]       res_data;
  logic [17:0]       dsp_a;
  logic [17:0]       dsp_b;
  logic [7:0]        dsp_opmode;
  logic [47:0]       dsp_p;

  always #5 clk = ~clk;

  dsp_mac_sequencer #(.LEN_W(LEN_W), .PIPE_LAT(3), .OPM_DLY(1)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .len        (len),
    .busy       (busy),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .res_valid  (res_valid),
    .res_data   (res_data),
    .dsp_a      (dsp_a),
    .dsp_b      (dsp_b),
    .dsp_opmode (dsp_opmode),
    .dsp_p      (dsp_p)
  );

  // Slice model: A1/B1 -> M -> P, OPMODE registered once.
  logic signed [17:0] m_a1, m_b1;
  logic signed [35:0] m_m;
  logic [7:0]         m_opr;
  logic [47:0]        m_p;
  logic [47:0]        m_x, m_z;
  assign m_x   = (m_opr[1:0] == 2'b01) ? {{12{m_m[35]}}, m_m} : 48'd0;
  assign m_z   = (m_opr[3:2] == 2'b10) ? m_p : 48'd0;
  assign dsp_p = m_p;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_a1 <= '0; m_b1 <= '0; m_m <= '0; m_opr <= '0; m_p <= '0;
    end else begin
      m_a1  <= dsp_a;
      m_b1  <= dsp_b;
      m_m   <= m_a1 * m_b1;
      m_opr <= dsp_opmode;
      m_p   <= m_x + m_z;
    end
  end

  int tests_run = 0;
  int tests_failed = 0;

  logic signed [17:0] ta[256];
  logic signed [17:0] tbv[256];
  bit                 vpat[$];
  logic [7:0]         opq[$];
  bit                 rdy_log[$];
  logic [47:0]        res;
  bit                 got;
  int                 res_cyc;
  int                 n_acc;
  int                 pulse_cyc = -1;

  // Called at a negedge; returns at the negedge after res_valid (or on timeout).
  task automatic drive_job(input int n);
    int cyc;
    int idx;
    bit v;
    start = 1'b1;
    len   = n[LEN_W-1:0];
    @(negedge clk);
    start = 1'b0;
    cyc = 0; idx = 0; got = 0;
    opq.delete(); rdy_log.delete();
    while (!got && cyc < 700) begin
      opq.push_back(dsp_opmode);
      rdy_log.push_back(in_ready);
      if (res_valid) begin
        got = 1; res = res_data; res_cyc = cyc;
      end
      start = (cyc == pulse_cyc);
      if (cyc == pulse_cyc) len = 8'd5;
      v = (idx < n) && ((cyc < vpat.size()) ? vpat[cyc] : 1'b1);
      in_valid = v;
      if (idx < n) begin
        in_a = ta[idx];
        in_b = tbv[idx];
      end
      if (v && in_ready) idx++;
      cyc++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    start    = 1'b0;
    n_acc    = idx;
    if (!got) begin
      tests_run++; tests_failed++;
      $display("FAIL job_timeout: no res_valid within %0d cycles (len=%0d)", cyc, n);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; len = 8'd3; in_valid = 1'b1; in_a = 18'd7; in_b = 18'd7;
    repeat (3) @(negedge clk);
    tests_run++;
    if ({busy, in_ready, res_valid} !== 3'b000) begin
      tests_failed++; $display("FAIL reset_flags: got %b want 000", {busy, in_ready, res_valid});
    end
    tests_run++;
    if (res_data !== 48'd0 || dsp_a !== 18'd0 || dsp_b !== 18'd0) begin
      tests_failed++;
      $display("FAIL reset_data: got res=%h a=%h b=%h want 0", res_data, dsp_a, dsp_b);
    end
    tests_run++;
    if (dsp_opmode !== 8'h08) begin
      tests_failed++; $display("FAIL reset_opmode: got %h want 08", dsp_opmode);
    end
    start = 1'b0;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    tests_run++;
    if (in_ready !== 1'b0 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL idle_in_valid: got ready=%b busy=%b want 0 0", in_ready, busy);
    end
    in_valid = 1'b0;
  endtask

  task automatic test_single();
    ta[0] = 18'sd3; tbv[0] = 18'sd5; vpat.delete();
    drive_job(1);
    tests_run++;
    if (rdy_log[0] !== 1'b1 || rdy_log[1] !== 1'b0) begin
      tests_failed++;
      $display("FAIL single_ready: got %b%b want 10", rdy_log[0], rdy_log[1]);
    end
    tests_run++;
    if (opq[1] !== 8'h08 || opq[2] !== 8'h01 || opq[3] !== 8'h08) begin
      tests_failed++;
      $display("FAIL single_opmode: got %h %h %h want 08 01 08", opq[1], opq[2], opq[3]);
    end
    tests_run++;
    if (res_cyc !== 5) begin
      tests_failed++; $display("FAIL single_latency: got %0d want 5", res_cyc);
    end
    tests_run++;
    if (res !== 48'd15) begin
      tests_failed++; $display("FAIL single_result: got %0d want 15", res);
    end
    tests_run++;
    if (busy !== 1'b0 || res_valid !== 1'b0 || res_data !== 48'd15) begin
      tests_failed++;
      $display("FAIL single_after: got busy=%b rv=%b res=%0d want 0 0 15", busy, res_valid,
               res_data);
    end
  endtask

  task automatic test_len4();
    ta[0] = 18'sd1;  tbv[0] = 18'sd2;
    ta[1] = 18'sd3;  tbv[1] = 18'sd4;
    ta[2] = -18'sd5; tbv[2] = 18'sd6;
    ta[3] = 18'sd7;  tbv[3] = -18'sd8;
    vpat.delete();
    drive_job(4);
    tests_run++;
    if (opq[2] !== 8'h01 || opq[3] !== 8'h09 || opq[4] !== 8'h09 || opq[5] !== 8'h09) begin
      tests_failed++;
      $display("FAIL len4_opmode: got %h %h %h %h want 01 09 09 09", opq[2], opq[3], opq[4],
               opq[5]);
    end
    tests_run++;
    if (res !== 48'hFFFF_FFFF_FFB8) begin
      tests_failed++; $display("FAIL len4_result: got %h want ffffffffffb8", res);
    end
    tests_run++;
    if (res_cyc !== 8) begin
      tests_failed++; $display("FAIL len4_latency: got %0d want 8", res_cyc);
    end
  endtask

  task automatic test_mid_reset();
    bit seen;
    start = 1'b1; len = 8'd4;
    @(negedge clk);
    start = 1'b0; in_valid = 1'b1; in_a = 18'd9; in_b = 18'd9;
    @(negedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    tests_run++;
    if ({busy, in_ready, res_valid} !== 3'b000) begin
      tests_failed++; $display("FAIL midrst_flags: got %b want 000", {busy, in_ready, res_valid});
    end
    tests_run++;
    if (res_data !== 48'd0 || dsp_a !== 18'd0 || dsp_opmode !== 8'h08) begin
      tests_failed++;
      $display("FAIL midrst_values: got res=%h a=%h opm=%h want 0 0 08", res_data, dsp_a,
               dsp_opmode);
    end
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (res_valid || busy) seen = 1;
    end
    tests_run++;
    if (seen !== 1'b0) begin
      tests_failed++; $display("FAIL midrst_no_result: got activity=%b want 0", seen);
    end
    ta[0] = 18'sd2; tbv[0] = 18'sd2; vpat.delete();
    drive_job(1);
    tests_run++;
    if (res !== 48'd4) begin
      tests_failed++; $display("FAIL midrst_next_job: got %0d want 4", res);
    end
  endtask

  task automatic test_bubbles();
    ta[0] = 18'sd1; tbv[0] = 18'sd2;
    ta[1] = 18'sd3; tbv[1] = 18'sd4;
    ta[2] = -18'sd5; tbv[2] = 18'sd6;
    vpat = '{1, 0, 0, 1, 0, 1};
    drive_job(3);
    vpat.delete();
    tests_run++;
    if (opq[2] !== 8'h01 || opq[3] !== 8'h08 || opq[4] !== 8'h08 || opq[5] !== 8'h09 ||
        opq[6] !== 8'h08 || opq[7] !== 8'h09) begin
      tests_failed++;
      $display("FAIL bubble_opmode: got %h %h %h %h %h %h want 01 08 08 09 08 09", opq[2],
               opq[3], opq[4], opq[5], opq[6], opq[7]);
    end
    tests_run++;
    if (res !== 48'hFFFF_FFFF_FFF0) begin
      tests_failed++; $display("FAIL bubble_result: got %h want fffffffffff0", res);
    end
    tests_run++;
    if (rdy_log[5] !== 1'b1 || rdy_log[6] !== 1'b0 || res_cyc !== 10) begin
      tests_failed++;
      $display("FAIL bubble_ready: got rdy5=%b rdy6=%b rcyc=%0d want 1 0 10", rdy_log[5],
               rdy_log[6], res_cyc);
    end
  endtask

  task automatic test_zero_len();
    bit bad;
    drive_job(0);
    tests_run++;
    if (res_cyc !== 0 || res !== 48'd0) begin
      tests_failed++; $display("FAIL zero_len: got cyc=%0d res=%h want 0 0", res_cyc, res);
    end
    bad = 0;
    foreach (opq[i]) if (opq[i] !== 8'h08) bad = 1;
    if (dsp_opmode !== 8'h08) bad = 1;
    tests_run++;
    if (bad !== 1'b0) begin
      tests_failed++; $display("FAIL zero_len_opmode: got non-hold=%b want 0", bad);
    end
  endtask

  task automatic test_back_to_back();
    bit seen;
    ta[0] = 18'sd100; tbv[0] = 18'sd100;
    ta[1] = 18'sd1;   tbv[1] = 18'sd1;
    pulse_cyc = 1;
    drive_job(2);
    pulse_cyc = -1;
    tests_run++;
    if (res !== 48'd10001 || res_cyc !== 6) begin
      tests_failed++;
      $display("FAIL b2b_job_a: got res=%0d cyc=%0d want 10001 6", res, res_cyc);
    end
    ta[0] = 18'sd7; tbv[0] = 18'sd7;
    drive_job(1);
    tests_run++;
    if (res !== 48'd49 || res_cyc !== 5 || opq[2] !== 8'h01) begin
      tests_failed++;
      $display("FAIL b2b_job_b: got res=%0d cyc=%0d opm=%h want 49 5 01", res, res_cyc, opq[2]);
    end
    seen = 0;
    repeat (8) begin
      if (busy || res_valid) seen = 1;
      @(negedge clk);
    end
    tests_run++;
    if (seen !== 1'b0) begin
      tests_failed++; $display("FAIL b2b_not_queued: got activity=%b want 0", seen);
    end
  endtask

  task automatic test_max_len();
    for (int i = 0; i < 255; i++) begin
      ta[i]  = 18'(i + 1);
      tbv[i] = 18'sd1;
    end
    drive_job(255);
    tests_run++;
    if (n_acc !== 255 || res !== 48'd32640) begin
      tests_failed++;
      $display("FAIL max_len: got acc=%0d res=%0d want 255 32640", n_acc, res);
    end
    tests_run++;
    if (res_cyc !== 259 || rdy_log[255] !== 1'b0) begin
      tests_failed++;
      $display("FAIL max_len_timing: got cyc=%0d rdy=%b want 259 0", res_cyc, rdy_log[255]);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_len4();
    test_mid_reset();
    test_bubbles();
    test_zero_len();
    test_back_to_back();
    test_max_len();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
